// File: rtl/uart_cmd_ctrl.sv
// -----------------------------------------------------------------------------
// uart_cmd_ctrl
//
// Command-frame controller between the 8N1 UART byte engine and the AD5761R
// SPI write driver. Parses 5-byte host frames {HDR, CMD, DH, DL, CHK} from the
// UART receive side, checks CHK == CMD^DH^DL, issues one DAC write per valid
// frame and sends an ACK/NAK response back to the host through the UART
// transmit side.
//
// Optional feature (macro UART_CMD_ECHO_DATA_EN):
//   defined   : ACK response is 4 bytes {ACK_BYTE, CMD, DH, DL}
//   undefined : ACK response is 2 bytes {ACK_BYTE, CMD}
//   NAK response is always 2 bytes {NAK_BYTE, CMD}.
//
// Ports:
//   iCLK, iRST_N          clock, asynchronous active-low reset
//   iRX_DONE, iRX_DATA    received byte strobe and data
//   oTX_REQ, oTX_DATA     transmit request level and byte
//   iTX_DONE              transmit finished strobe
//   oDAC_REQ              DAC write request level
//   oDAC_CMD, oDAC_DATA   AD5761R command nibble and {DH,DL}
//   iDAC_ACK              DAC write accepted strobe
//   oBUSY                 high whenever the FSM is not in HUNT
//   oERR                  one-cycle pulse on checksum failure or timeout
//   oDBG_STATE            current FSM state (debug / checker binding)
//
// Handshakes: oDAC_REQ and oTX_REQ are levels that stay high until the
// matching one-cycle done/ack pulse is sampled; the request drops on the
// same clock edge that samples the pulse, and the payload (oDAC_CMD/
// oDAC_DATA, oTX_DATA) is stable for the whole time the request is high.
// -----------------------------------------------------------------------------
module uart_cmd_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 240_000,
  parameter int unsigned GAP_CYC     = 4,
  parameter logic [7:0]  HDR_BYTE    = 8'hA5,
  parameter logic [7:0]  ACK_BYTE    = 8'h5A,
  parameter logic [7:0]  NAK_BYTE    = 8'hEE
) (
  input  logic        iCLK,
  input  logic        iRST_N,
  input  logic        iRX_DONE,
  input  logic [7:0]  iRX_DATA,
  output logic        oTX_REQ,
  output logic [7:0]  oTX_DATA,
  input  logic        iTX_DONE,
  output logic        oDAC_REQ,
  output logic [3:0]  oDAC_CMD,
  output logic [15:0] oDAC_DATA,
  input  logic        iDAC_ACK,
  output logic        oBUSY,
  output logic        oERR,
  output logic [3:0]  oDBG_STATE
);

`ifdef UART_CMD_ECHO_DATA_EN
  localparam int unsigned ACK_LEN = 4;
  localparam int unsigned IDX_W   = 2;
`else
  localparam int unsigned ACK_LEN = 2;
  localparam int unsigned IDX_W   = 1;
`endif
  localparam int unsigned GAP_W = $clog2(GAP_CYC);

  typedef enum logic [3:0] {
    HUNT     = 4'd0,
    GET_CMD  = 4'd1,
    GET_DH   = 4'd2,
    GET_DL   = 4'd3,
    GET_CHK  = 4'd4,
    DAC_REQ  = 4'd5,
    DAC_WAIT = 4'd6,
    TX_SEND  = 4'd7,
    TX_WAIT  = 4'd8,
    TX_GAP   = 4'd9
  } state_t;

  state_t             state_q, state_d;
  logic [7:0]         cmd_q, cmd_d;
  logic [7:0]         dh_q, dh_d;
  logic [7:0]         dl_q, dl_d;
  logic [23:0]        to_cnt_q, to_cnt_d;
  logic               nak_q, nak_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic               tx_req_q, tx_req_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic               dac_req_q, dac_req_d;
  logic               err_q, err_d;

  logic [7:0]         resp_byte;
  logic               last_byte;
  logic               to_expired;
  logic               in_get;

  assign to_expired = (to_cnt_q == 24'(TIMEOUT_CYC - 1));
  assign in_get     = (state_q == GET_CMD) || (state_q == GET_DH) ||
                      (state_q == GET_DL)  || (state_q == GET_CHK);

  // Response byte selected by the byte index; byte 0 is the ACK/NAK code.
  always_comb begin
    resp_byte = cmd_q;
    if (idx_q == '0) begin
      resp_byte = nak_q ? NAK_BYTE : ACK_BYTE;
    end
`ifdef UART_CMD_ECHO_DATA_EN
    else if (idx_q == 2'd2) begin
      resp_byte = dh_q;
    end else if (idx_q == 2'd3) begin
      resp_byte = dl_q;
    end
`endif
  end

  assign last_byte = nak_q ? (idx_q == IDX_W'(1)) : (idx_q == IDX_W'(ACK_LEN - 1));

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q   <= HUNT;
      cmd_q     <= '0;
      dh_q      <= '0;
      dl_q      <= '0;
      to_cnt_q  <= '0;
      nak_q     <= 1'b0;
      idx_q     <= '0;
      gap_q     <= '0;
      tx_req_q  <= 1'b0;
      tx_data_q <= '0;
      dac_req_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      dh_q      <= dh_d;
      dl_q      <= dl_d;
      to_cnt_q  <= to_cnt_d;
      nak_q     <= nak_d;
      idx_q     <= idx_d;
      gap_q     <= gap_d;
      tx_req_q  <= tx_req_d;
      tx_data_q <= tx_data_d;
      dac_req_q <= dac_req_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    dh_d      = dh_q;
    dl_d      = dl_q;
    to_cnt_d  = to_cnt_q;
    nak_d     = nak_q;
    idx_d     = idx_q;
    gap_d     = gap_q;
    tx_req_d  = tx_req_q;
    tx_data_d = tx_data_q;
    dac_req_d = dac_req_q;
    err_d     = 1'b0;

    case (state_q)
      HUNT: begin
        to_cnt_d = '0;
        if (iRX_DONE && (iRX_DATA == HDR_BYTE)) begin
          state_d = GET_CMD;
        end
      end
      GET_CMD: begin
        if (iRX_DONE) begin
          cmd_d   = iRX_DATA;
          state_d = GET_DH;
        end
      end
      GET_DH: begin
        if (iRX_DONE) begin
          dh_d    = iRX_DATA;
          state_d = GET_DL;
        end
      end
      GET_DL: begin
        if (iRX_DONE) begin
          dl_d    = iRX_DATA;
          state_d = GET_CHK;
        end
      end
      GET_CHK: begin
        if (iRX_DONE) begin
          idx_d = '0;
          if (iRX_DATA == (cmd_q ^ dh_q ^ dl_q)) begin
            nak_d   = 1'b0;
            state_d = DAC_REQ;
          end else begin
            nak_d   = 1'b1;
            err_d   = 1'b1;
            state_d = TX_SEND;
          end
        end
      end
      DAC_REQ: begin
        dac_req_d = 1'b1;
        state_d   = DAC_WAIT;
      end
      DAC_WAIT: begin
        if (iDAC_ACK) begin
          dac_req_d = 1'b0;
          nak_d     = 1'b0;
          idx_d     = '0;
          state_d   = TX_SEND;
        end
      end
      TX_SEND: begin
        // Data is registered here; the request rises one edge later.
        tx_data_d = resp_byte;
        state_d   = TX_WAIT;
      end
      TX_WAIT: begin
        // A done pulse only counts once our request is actually visible.
        if (iTX_DONE && tx_req_q) begin
          tx_req_d = 1'b0;
          gap_d    = '0;
          state_d  = TX_GAP;
        end else begin
          tx_req_d = 1'b1;
        end
      end
      TX_GAP: begin
        if (gap_q == GAP_W'(GAP_CYC - 1)) begin
          if (last_byte) begin
            idx_d   = '0;
            state_d = HUNT;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = TX_SEND;
          end
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      default: begin
        state_d = HUNT;
      end
    endcase

    // Inter-byte timeout shared by all GET_* states. An arriving byte beats
    // expiry in the same cycle and clears the counter.
    if (in_get) begin
      if (iRX_DONE) begin
        to_cnt_d = '0;
      end else if (to_expired) begin
        to_cnt_d = '0;
        err_d    = 1'b1;
        state_d  = HUNT;
      end else begin
        to_cnt_d = to_cnt_q + 24'd1;
      end
    end
  end

  assign oTX_REQ    = tx_req_q;
  assign oTX_DATA   = tx_data_q;
  assign oDAC_REQ   = dac_req_q;
  assign oDAC_CMD   = cmd_q[3:0];
  assign oDAC_DATA  = {dh_q, dl_q};
  assign oBUSY      = (state_q != HUNT);
  assign oERR       = err_q;
  assign oDBG_STATE = state_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// -----------------------------------------------------------------------------
// tb_uart_cmd_ctrl
//
// Directed bench for uart_cmd_ctrl. Background responders answer DAC and UART
// transmit requests; transmitted bytes are compared against an expected queue.
// -----------------------------------------------------------------------------
module tb_uart_cmd_ctrl;

  localparam int unsigned T_CYC = 40;
  localparam int unsigned G_CYC = 4;

  logic        iCLK;
  logic        iRST_N;
  logic        iRX_DONE;
  logic [7:0]  iRX_DATA;
  logic        oTX_REQ;
  logic [7:0]  oTX_DATA;
  logic        iTX_DONE;
  logic        oDAC_REQ;
  logic [3:0]  oDAC_CMD;
  logic [15:0] oDAC_DATA;
  logic        iDAC_ACK;
  logic        oBUSY;
  logic        oERR;
  logic [3:0]  oDBG_STATE;

  uart_cmd_ctrl #(
    .TIMEOUT_CYC(T_CYC),
    .GAP_CYC    (G_CYC)
  ) dut (
    .iCLK      (iCLK),
    .iRST_N    (iRST_N),
    .iRX_DONE  (iRX_DONE),
    .iRX_DATA  (iRX_DATA),
    .oTX_REQ   (oTX_REQ),
    .oTX_DATA  (oTX_DATA),
    .iTX_DONE  (iTX_DONE),
    .oDAC_REQ  (oDAC_REQ),
    .oDAC_CMD  (oDAC_CMD),
    .oDAC_DATA (oDAC_DATA),
    .iDAC_ACK  (iDAC_ACK),
    .oBUSY     (oBUSY),
    .oERR      (oERR),
    .oDBG_STATE(oDBG_STATE)
  );

  // ---------------- clock / reset ----------------
  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  int         dac_delay  = 3;
  int         dac_cnt    = 0;
  int         dac_hi     = 0;
  int         dac_max_hi = 0;
  int         dac_unstab = 0;
  logic [3:0] dac_cmd_l  = '0;
  logic [15:0] dac_data_l = '0;

  int         tx_hi      = 0;
  int         tx_low     = 1000;
  int         tx_unstab  = 0;
  int         tx_gap_bad = 0;
  logic       tx_req_prev = 1'b0;
  logic [7:0] tx_data_prev = '0;
  logic [7:0] tx_hold = '0;

  int         err_cnt   = 0;
  int         err_multi = 0;
  logic       err_prev  = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // ---------------- responders / monitors (sample on negedge) ----------------
  always @(negedge iCLK) begin
    // DAC: acknowledge after dac_delay cycles of request.
    if (oDAC_REQ) begin
      if (dac_hi == 0) begin
        dac_cnt++;
        dac_cmd_l  = oDAC_CMD;
        dac_data_l = oDAC_DATA;
      end else if ({oDAC_CMD, oDAC_DATA} !== {dac_cmd_l, dac_data_l}) begin
        dac_unstab++;
      end
      dac_hi++;
      if (dac_hi > dac_max_hi) dac_max_hi = dac_hi;
      iDAC_ACK = (dac_hi == dac_delay);
    end else begin
      dac_hi   = 0;
      iDAC_ACK = 1'b0;
    end

    // UART transmit: capture on rising request, finish after 5 cycles.
    if (oTX_REQ) begin
      if (!tx_req_prev) begin
        got_q.push_back(oTX_DATA);
        tx_hold = oTX_DATA;
        if (oTX_DATA !== tx_data_prev) tx_unstab++;
        if (tx_low < G_CYC) tx_gap_bad++;
        tx_hi = 0;
      end else if (oTX_DATA !== tx_hold) begin
        tx_unstab++;
      end
      tx_hi++;
      iTX_DONE = (tx_hi == 5);
      tx_low   = 0;
    end else begin
      iTX_DONE = 1'b0;
      tx_hi    = 0;
      tx_low++;
    end
    tx_req_prev  = oTX_REQ;
    tx_data_prev = oTX_DATA;

    if (oERR) begin
      err_cnt++;
      if (err_prev) err_multi++;
    end
    err_prev = oERR;
  end

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] b);
    @(negedge iCLK);
    iRX_DATA = b;
    iRX_DONE = 1'b1;
    @(negedge iCLK);
    iRX_DONE = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [7:0] h, input logic [7:0] l,
                            input logic [7:0] k);
    send_byte(8'hA5);
    send_byte(c);
    send_byte(h);
    send_byte(l);
    send_byte(k);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (oBUSY && n < 3000) begin
      @(negedge iCLK);
      n++;
    end
    check_eq(tag, {31'd0, oBUSY}, 32'd0);
    repeat (3) @(negedge iCLK);
  endtask

  task automatic wait_tx_req(input string tag);
    int n;
    n = 0;
    while (!oTX_REQ && n < 500) begin
      @(negedge iCLK);
      n++;
    end
    check_eq(tag, {31'd0, oTX_REQ}, 32'd1);
  endtask

  task automatic push_ack(input logic [7:0] c, input logic [7:0] h, input logic [7:0] l);
    exp_q.push_back(8'h5A);
    exp_q.push_back(c);
`ifdef UART_CMD_ECHO_DATA_EN
    exp_q.push_back(h);
    exp_q.push_back(l);
`else
    if (h === 8'hxx || l === 8'hxx) exp_q.push_back(8'h00);
`endif
  endtask

  task automatic check_tx(input string tag);
    int n;
    check_eq({tag, "_txlen"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check_eq($sformatf("%s_tx%0d", tag, i), {24'd0, got_q[i]}, {24'd0, exp_q[i]});
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_txreq"},  {31'd0, oTX_REQ},  32'd0);
    check_eq({tag, "_txdata"}, {24'd0, oTX_DATA}, 32'd0);
    check_eq({tag, "_dacreq"}, {31'd0, oDAC_REQ}, 32'd0);
    check_eq({tag, "_daccmd"}, {28'd0, oDAC_CMD}, 32'd0);
    check_eq({tag, "_dacdat"}, {16'd0, oDAC_DATA}, 32'd0);
    check_eq({tag, "_busy"},   {31'd0, oBUSY},    32'd0);
    check_eq({tag, "_err"},    {31'd0, oERR},     32'd0);
  endtask

  // ---------------- stimulus ----------------
  int dac0;
  int err0;

  initial begin
    iRST_N   = 1'b0;
    iRX_DONE = 1'b0;
    iRX_DATA = '0;
    iTX_DONE = 1'b0;
    iDAC_ACK = 1'b0;

    // Reset values
    repeat (3) @(negedge iCLK);
    check_outputs_zero("reset");
    iRST_N = 1'b1;
    repeat (2) @(negedge iCLK);

    // 1. Valid frame, with 2-cycle CHK -> oDAC_REQ latency
    send_frame(8'h03, 8'h12, 8'h34, 8'h25);
    check_eq("lat_cyc1", {31'd0, oDAC_REQ}, 32'd0);
    @(negedge iCLK);
    check_eq("lat_cyc2", {31'd0, oDAC_REQ}, 32'd1);
    push_ack(8'h03, 8'h12, 8'h34);
    wait_idle("valid_idle");
    check_eq("valid_dacn", dac_cnt, 1);
    check_eq("valid_cmd", {28'd0, dac_cmd_l}, 32'h3);
    check_eq("valid_data", {16'd0, dac_data_l}, 32'h1234);
    check_eq("valid_err", err_cnt, 0);
    check_tx("valid");

    // 2. Bad checksum
    dac0 = dac_cnt;
    send_frame(8'h03, 8'h12, 8'h34, 8'h00);
    exp_q.push_back(8'hEE);
    exp_q.push_back(8'h03);
    wait_idle("badchk_idle");
    check_eq("badchk_dacn", dac_cnt, dac0);
    check_eq("badchk_err", err_cnt, 1);
    check_tx("badchk");

    // 3. Leading garbage ignored
    send_byte(8'h00);
    send_byte(8'hFF);
    send_frame(8'h04, 8'h00, 8'h01, 8'h05);
    push_ack(8'h04, 8'h00, 8'h01);
    wait_idle("garb_idle");
    check_eq("garb_dacn", dac_cnt, dac0 + 1);
    check_eq("garb_cmd", {28'd0, dac_cmd_l}, 32'h4);
    check_eq("garb_data", {16'd0, dac_data_l}, 32'h0001);
    check_eq("garb_err", err_cnt, 1);
    check_tx("garb");

    // 4a. Timeout: error pulse exactly T_CYC cycles after the last byte
    send_byte(8'hA5);
    send_byte(8'h03);
    repeat (T_CYC - 1) @(negedge iCLK);
    check_eq("to_early", {31'd0, oERR}, 32'd0);
    @(negedge iCLK);
    check_eq("to_pulse", {31'd0, oERR}, 32'd1);
    check_eq("to_hunt", {31'd0, oBUSY}, 32'd0);
    @(negedge iCLK);
    check_eq("to_1cyc", {31'd0, oERR}, 32'd0);
    repeat (20) @(negedge iCLK);
    check_eq("to_errn", err_cnt, 2);
    check_tx("to");

    // 4b. Byte landing on the expiry cycle is accepted
    send_byte(8'hA5);
    send_byte(8'h03);
    repeat (T_CYC - 2) @(negedge iCLK);
    send_byte(8'h12);
    send_byte(8'h34);
    send_byte(8'h25);
    push_ack(8'h03, 8'h12, 8'h34);
    wait_idle("edge_idle");
    check_eq("edge_err", err_cnt, 2);
    check_eq("edge_data", {16'd0, dac_data_l}, 32'h1234);
    check_tx("edge");

    // 5. Slow DAC ack, bytes injected during DAC wait and TX
    dac_delay  = 100;
    dac_max_hi = 0;
    dac0       = dac_cnt;
    send_frame(8'h07, 8'hAB, 8'hCD, 8'h61);
    repeat (10) @(negedge iCLK);
    send_frame(8'h01, 8'h02, 8'h03, 8'h00);
    wait_tx_req("slow_txreq");
    send_frame(8'h01, 8'h02, 8'h03, 8'h00);
    push_ack(8'h07, 8'hAB, 8'hCD);
    wait_idle("slow_idle");
    check_eq("slow_dacn", dac_cnt, dac0 + 1);
    check_eq("slow_hi", dac_max_hi, 100);
    check_eq("slow_data", {16'd0, dac_data_l}, 32'hABCD);
    check_eq("dac_stable", dac_unstab, 0);
    check_eq("tx_stable", tx_unstab, 0);
    check_eq("tx_gap", tx_gap_bad, 0);
    check_tx("slow");
    dac_delay = 3;

    // 6. Reset during TX_WAIT
    send_frame(8'h04, 8'h00, 8'h01, 8'h05);
    wait_tx_req("rst_txreq");
    @(negedge iCLK);
    iRST_N = 1'b0;
    #1;
    check_outputs_zero("rstmid");
    repeat (3) @(negedge iCLK);
    iRST_N = 1'b1;
    repeat (10) @(negedge iCLK);
    got_q.delete();
    exp_q.delete();
    err0 = err_cnt;
    send_frame(8'h09, 8'h55, 8'hAA, 8'hF6);
    push_ack(8'h09, 8'h55, 8'hAA);
    wait_idle("post_idle");
    check_eq("post_cmd", {28'd0, dac_cmd_l}, 32'h9);
    check_eq("post_data", {16'd0, dac_data_l}, 32'h55AA);
    check_eq("post_err", err_cnt, err0);
    check_tx("post");

    check_eq("err_multi", err_multi, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
